// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: types and constants shared by the ADC responder slice.
//   adc_resp_state_t : frame-serving FSM states
//   ADC_EOF_MARKER   : value on dat that ends a frame
//   ADC_CLAMP_VALUE  : stored in place of 8'hFF samples when clamping is enabled
package adc_resp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_REQ  = 3'd2,
    SERVE     = 3'd3,
    WAIT_DROP = 3'd4,
    DONE      = 3'd5
  } adc_resp_state_t;

  localparam logic [7:0] ADC_EOF_MARKER  = 8'hFF;
  localparam logic [7:0] ADC_CLAMP_VALUE = 8'hFE;

endpackage

// File: rtl/adc_responder_if.sv
// adc_responder_if: bundles the sample front-end and consumer handshake.
//   smp_valid/smp_data : front-end sample strobe and value (into the responder)
//   req                : consumer request level (into the responder)
//   start              : one-cycle "frame ready" pulse
//   rdy/dat            : one-cycle read strobe and the sample or EOF marker
//   len                : constant frame length
//   ovf                : sticky overflow flag
// Modports: master = front-end/consumer side, slave = responder side.
interface adc_responder_if;
  logic       smp_valid;
  logic [7:0] smp_data;
  logic       req;
  logic       start;
  logic       rdy;
  logic [7:0] dat;
  logic [7:0] len;
  logic       ovf;

  modport master (
    output smp_valid, smp_data, req,
    input  start, rdy, dat, len, ovf
  );

  modport slave (
    input  smp_valid, smp_data, req,
    output start, rdy, dat, len, ovf
  );
endinterface

// File: rtl/adc_resp_fifo.sv
// adc_resp_fifo: DEPTH-entry sample FIFO with first-word-fall-through read.
//   clk, rst   : clock, synchronous active-high reset (pointers and count only)
//   push/wdata : write strobe and data; ignored while full
//   pop        : read strobe; ignored while empty
//   rdata      : current head entry
//   count      : occupancy, $clog2(DEPTH)+1 bits
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module adc_resp_fifo #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/adc_responder.sv
// adc_responder: buffers ADC samples and serves them as LEN-sample frames
// over a req/rdy handshake, each frame closed by the 8'hFF marker.
//   clk : clock
//   rst : synchronous active-high reset; abandons any frame in progress
//   bus : adc_responder_if.slave (smp_valid, smp_data, req -> start, rdy,
//         dat, len, ovf)
// Parameters: DEPTH (FIFO entries, power of two), LEN (samples per frame,
// 1..DEPTH).
// Build option: define ADC_RESP_CLAMP_EN to store 8'hFF samples as 8'hFE so
// only the end-of-frame marker carries 8'hFF.
module adc_responder
  import adc_resp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int LEN   = 16
) (
  input  logic           clk,
  input  logic           rst,
  adc_responder_if.slave bus
);
  localparam int             CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  LEN_C = CW'(LEN);

  adc_resp_state_t state, state_nxt;
  logic [CW-1:0]   served;
  logic            mark_sent;
  logic [7:0]      dat_q;
  logic            ovf_q;

  logic [7:0]      wdata;
  logic [7:0]      fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            serve_data;
  logic            pop;
  logic            start_c;
  logic            rdy_c;
  logic [7:0]      dat_c;

`ifdef ADC_RESP_CLAMP_EN
  assign wdata = (bus.smp_data == ADC_EOF_MARKER) ? ADC_CLAMP_VALUE : bus.smp_data;
`else
  assign wdata = bus.smp_data;
`endif

  // Until LEN samples have gone out, a SERVE cycle carries data; after that
  // it carries the marker.
  assign serve_data = (served < LEN_C);
  assign pop        = (state == SERVE) && serve_data && !fifo_empty;

  adc_resp_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.smp_valid),
    .wdata (wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (fifo_count >= LEN_C) state_nxt = ARM;
      ARM:       state_nxt = WAIT_REQ;
      WAIT_REQ:  if (bus.req) state_nxt = SERVE;
      SERVE:     state_nxt = WAIT_DROP;
      // Waiting for req to fall keeps one req assertion to one rdy.
      WAIT_DROP: if (!bus.req) state_nxt = mark_sent ? DONE : WAIT_REQ;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_c = (state == ARM);
    rdy_c   = (state == SERVE);
    dat_c   = dat_q;
    if (state == SERVE) dat_c = serve_data ? fifo_rdata : ADC_EOF_MARKER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      served    <= '0;
      mark_sent <= 1'b0;
      dat_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (state == ARM) begin
        served    <= '0;
        mark_sent <= 1'b0;
      end
      if (state == SERVE) begin
        dat_q <= dat_c;
        if (serve_data) served    <= served + CW'(1);
        else            mark_sent <= 1'b1;
      end
      if (bus.smp_valid && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign bus.start = start_c;
  assign bus.rdy   = rdy_c;
  assign bus.dat   = dat_c;
  assign bus.len   = 8'(LEN);
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_adc_responder.sv
module tb_adc_responder;
  import adc_resp_pkg::*;

  localparam int DEPTH = 32;
  localparam int LEN   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_responder_if bus ();

  adc_responder #(.DEPTH(DEPTH), .LEN(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb [$];
  int model_cnt = 0;
  int rdy_cnt   = 0;
  int start_cnt = 0;

  always @(negedge clk) begin
    if (bus.rdy === 1'b1)   rdy_cnt++;
    if (bus.start === 1'b1) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] stored(input logic [7:0] v);
`ifdef ADC_RESP_CLAMP_EN
    return (v == 8'hFF) ? 8'hFE : v;
`else
    return v;
`endif
  endfunction

  task automatic push(input logic [7:0] v);
    bus.smp_valid = 1'b1;
    bus.smp_data  = v;
    if (model_cnt < DEPTH) begin
      sb.push_back(stored(v));
      model_cnt++;
    end
    tick();
    bus.smp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.smp_valid = 1'b0;
    bus.req = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    model_cnt = 0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (bus.start !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, bus.start, 1);
    tick();
  endtask

  // One req/rdy handshake; expects the FSM to be waiting in WAIT_REQ.
  task automatic read_one(input string tag, input bit marker);
    int n;
    logic [7:0] exp;
    bus.req = 1'b1;
    n = 0;
    while (bus.rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rdy_latency"}, n, 1);
    if (marker) begin
      exp = ADC_EOF_MARKER;
    end else if (sb.size() == 0) begin
      exp = 8'h00;
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      exp = sb.pop_front();
      model_cnt--;
    end
    chk(tag, bus.dat, exp);
    bus.req = 1'b0;
    tick();
    chk({tag, "_rdy_drop"}, bus.rdy, 0);
    tick();
  endtask

  initial begin
    int s0;
    int r0;
    logic [7:0] exp;

    rst = 1'b1;
    bus.smp_valid = 1'b0;
    bus.smp_data = 8'h00;
    bus.req = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_start", bus.start, 0);
    chk("rst_rdy", bus.rdy, 0);
    chk("rst_dat", bus.dat, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("len", bus.len, LEN);
    chk("rst_count", dut.u_fifo.count, 0);
    chk("rst_state", dut.state, IDLE);

    // 15 samples: no frame; the 16th arms one two cycles later.
    s0 = start_cnt;
    for (int i = 1; i <= 15; i++) push(8'(i));
    repeat (4) tick();
    chk("no_start_15", start_cnt - s0, 0);
    push(8'h10);
    chk("start_lat_c1", bus.start, 0);
    tick();
    chk("start_lat_c2", bus.start, 1);
    tick();
    chk("start_one_cycle", bus.start, 0);
    for (int i = 0; i < LEN; i++) read_one($sformatf("f1_d%0d", i), 1'b0);
    read_one("f1_eof", 1'b1);
    tick();
    chk("f1_idle", dut.state, IDLE);
    chk("f1_start_once", start_cnt - s0, 1);
    chk("f1_count", dut.u_fifo.count, 0);

    // req held high for 5 cycles gives exactly one rdy.
    for (int i = 0; i < LEN; i++) push(8'h20 + 8'(i));
    wait_start("f2_start");
    r0 = rdy_cnt;
    bus.req = 1'b1;
    repeat (5) tick();
    exp = sb.pop_front();
    model_cnt--;
    chk("hold_dat", bus.dat, exp);
    chk("hold_one_rdy", rdy_cnt - r0, 1);
    bus.req = 1'b0;
    tick();
    for (int i = 1; i < LEN; i++) read_one($sformatf("f2_d%0d", i), 1'b0);
    read_one("f2_eof", 1'b1);
    tick();
    chk("f2_idle", dut.state, IDLE);

    // 33 pushes into 32 entries: overflow, 33rd sample never read out.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push(8'h40 + 8'(i));
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_count", dut.u_fifo.count, DEPTH);
    for (int i = 0; i < LEN; i++) read_one($sformatf("ov1_d%0d", i), 1'b0);
    read_one("ov1_eof", 1'b1);
    wait_start("ov2_start");
    for (int i = 0; i < LEN; i++) read_one($sformatf("ov2_d%0d", i), 1'b0);
    read_one("ov2_eof", 1'b1);
    chk("ov_sb_drained", sb.size(), 0);
    chk("ov_count_zero", dut.u_fifo.count, 0);
    chk("ovf_sticky", bus.ovf, 1);

    // 8'hFF sample: clamped or passed through depending on the build.
    do_reset();
    push(8'hFF);
    for (int i = 1; i < LEN; i++) push(8'h80 + 8'(i));
    wait_start("clamp_start");
    read_one("clamp_ff", 1'b0);
    for (int i = 1; i < 5; i++) read_one($sformatf("rs_d%0d", i), 1'b0);

    // Overflow mid-frame, then reset abandons the frame.
    for (int i = 0; i < 25; i++) push(8'hA0 + 8'(i));
    chk("rs_ovf_before", bus.ovf, 1);
    rst = 1'b1;
    tick();
    chk("rs_rdy", bus.rdy, 0);
    chk("rs_start", bus.start, 0);
    chk("rs_ovf", bus.ovf, 0);
    chk("rs_count", dut.u_fifo.count, 0);
    chk("rs_state", dut.state, IDLE);
    chk("rs_dat", bus.dat, 0);
    rst = 1'b0;
    sb.delete();
    model_cnt = 0;
    r0 = rdy_cnt;
    bus.req = 1'b1;
    repeat (6) tick();
    bus.req = 1'b0;
    tick();
    chk("rs_no_marker", rdy_cnt - r0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_responder.md
ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 Parameter DEPTH, default 32: sample buffer depth in entries, power of two.
REQ-002 Parameter LEN, default 16: samples per frame, legal range 1..DEPTH.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 smp_valid  in  1  front-end sample strobe, one sample per high cycle.
REQ-006 smp_data  in  8  front-end sample value.
REQ-007 req  in  1  consumer request, level; consumer drops it the cycle after it sees rdy.
REQ-008 start  out  1  one-cycle pulse announcing that a frame is ready to be read.
REQ-009 rdy  out  1  one-cycle strobe; dat is valid while rdy is high.
REQ-010 dat  out  8  sample or end-of-frame marker 8'hFF.
REQ-011 len  out  8  constant LEN, the frame length in samples.
REQ-012 ovf  out  1  sticky overflow flag.

Function
REQ-013 Samples are held in a DEPTH-entry FIFO with read/write pointers and a count of width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-014 On smp_valid with the FIFO not full, the sample is pushed; on smp_valid with the FIFO full, the sample is dropped and ovf is set until rst.
REQ-015 A push and a pop in the same cycle leave count unchanged; a push while full is dropped even if a pop occurs in that cycle.
REQ-016 FSM states: IDLE, ARM, WAIT_REQ, SERVE, WAIT_DROP, DONE.
REQ-017 IDLE -> ARM when count >= LEN; ARM drives start=1 for exactly one cycle and clears the served counter, then goes to WAIT_REQ.
REQ-018 WAIT_REQ -> SERVE when req is sampled high; rdy rises exactly one cycle after req is sampled high.
REQ-019 SERVE drives rdy=1 for exactly one cycle.
REQ-020 In SERVE with served < LEN: dat = FIFO head, the head is popped, and served increments.
REQ-021 In SERVE with served == LEN: dat = 8'hFF, and nothing is popped.
REQ-022 SERVE -> WAIT_DROP; WAIT_DROP holds until req is sampled low, so no second rdy is issued for a single req assertion.
REQ-023 WAIT_DROP exits on req low: to WAIT_REQ if the marker has not yet been sent, to DONE if it has.
REQ-024 DONE -> IDLE unconditionally after one cycle; back-to-back frames are allowed when count >= LEN again.
REQ-025 dat holds its last value outside SERVE; start and rdy are 0 in every state except ARM and SERVE respectively.
REQ-026 The FIFO keeps accepting samples in all states; a frame already armed always has LEN samples available, so no underflow path exists.

Reset
REQ-027 On rst high at a clock edge: state=IDLE, pointers=0, count=0, served=0, start=0, rdy=0, dat=0, ovf=0.
REQ-028 rst high in the middle of a frame abandons it: no marker is sent and buffered samples are discarded.

Configuration
REQ-029 Macro ADC_RESP_CLAMP_EN: when defined, a pushed sample equal to 8'hFF is stored as 8'hFE, so only the marker carries 8'hFF.
REQ-030 When ADC_RESP_CLAMP_EN is undefined, samples are stored unmodified, and a data 8'hFF is indistinguishable from the marker.

Structure
REQ-031 Package adc_resp_pkg holds: the state enum type adc_resp_state_t, the constant ADC_EOF_MARKER = 8'hFF, and the constant ADC_CLAMP_VALUE = 8'hFE.
REQ-032 The FIFO is a separate sub-module, adc_resp_fifo (push, pop, data, count, full, empty); the FSM, counters and the clamp stay in adc_responder.

Verification
REQ-033 Push 16 samples 0x01..0x10, LEN=16 -> start pulses once; 16 req/rdy handshakes return 0x01..0x10 in order; the 17th handshake returns 0xFF; FSM returns to IDLE.
REQ-034 Push 15 samples -> no start; push a 16th -> start pulses exactly two cycles after that push.
REQ-035 Hold req high for 5 cycles -> exactly one rdy pulse; next rdy only after req is low for at least one cycle.
REQ-036 Push 33 samples with no reads, DEPTH=32 -> ovf=1, count=32, 33rd sample absent from readout.
REQ-037 With the macro defined, push 0xFF -> read back 0xFE; without the macro -> read back 0xFF.
REQ-038 Assert rst after 5 of 16 samples are served -> next cycle rdy=0, start=0, ovf=0, count=0, state IDLE; no marker is sent.
